// File: rtl/smg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : smg_pkg
//  Description : Shared constants and types for the seven-segment scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package smg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Common-anode, active-low segment codes; index = hex digit value.
    localparam logic [15:0][7:0] SEG_CODE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } cnv_state_t;

endpackage
`default_nettype wire

// File: rtl/smg_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : smg_scan_driver_if
//  Description : Value/control inputs and display outputs of the scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface smg_scan_driver_if #(
    parameter int DIGITS = 4,
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] data_in;
    logic              load;
    logic              hex_mode;
    logic              blank_lz;
    logic              ready;
    logic              overflow;
    logic [DIGITS-1:0] cs;
    logic [7:0]        dx;

    modport master (
        output data_in, load, hex_mode, blank_lz,
        input  ready, overflow, cs, dx
    );

    modport slave (
        input  data_in, load, hex_mode, blank_lz,
        output ready, overflow, cs, dx
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble converter, one bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import smg_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(DATA_W - 1);

    cnv_state_t          r_state;
    logic [DATA_W-1:0]   r_bin;
    logic [BCD_W-1:0]    r_bcd;
    logic [CNT_W-1:0]    r_iter;
    logic                r_ovf;
    logic                r_busy;
    logic                r_done;
    logic [BCD_W-1:0]    w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_bin   <= bin;
                        r_bcd   <= '0;
                        r_iter  <= '0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Bit leaving the top nibble means the value needs more digits.
                    r_bcd  <= {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
                    r_bin  <= r_bin << 1;
                    r_iter <= r_iter + 1'b1;
                    if (w_adj[BCD_W-1]) begin
                        r_ovf <= 1'b1;
                    end
                    if (r_iter == c_last_iter) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: rtl/smg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : smg_scan_driver
//  Description : Multiplexed common-anode seven-segment driver, hex/decimal.
//  Revision    : 1.0 - initial release
// ============================================================================
module smg_scan_driver
    import smg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DATA_W   = 16,
    parameter int SCAN_CYC = 50_000
) (
    input  logic              clk,
    input  logic              rst_n,
    smg_scan_driver_if.slave  bus
);
    localparam int BUF_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(SCAN_CYC);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_CYC - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DIGITS - 1);

    logic               w_busy;
    logic               w_done;
    logic               w_cnv_ovf;
    logic [BUF_W-1:0]   w_bcd;
    logic               w_ready;
    logic               w_hex_wr;
    logic               w_dec_start;
    logic [BUF_W-1:0]   w_data_ext;
    logic [BUF_W-1:0]   w_buf_nxt;
    logic [DIGITS-1:0]  w_digit_nz;
    logic [DIGITS-1:0]  w_zero_above;
    logic [3:0]         w_nib;
    logic               w_blank;
    logic [DIGITS-1:0]  w_cs_nxt;
    logic [7:0]         w_seg;

    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [BUF_W-1:0]   r_buf;
    logic               r_ovf;
    logic [DIGITS-1:0]  r_cs;
    logic [7:0]         r_dx;

    assign w_ready     = ~w_busy;
    assign w_hex_wr    = bus.load & w_ready & bus.hex_mode;
    assign w_dec_start = bus.load & w_ready & ~bus.hex_mode;
    assign w_data_ext  = BUF_W'(bus.data_in);

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_dec_start),
        .bin      (bus.data_in),
        .busy     (w_busy),
        .done     (w_done),
        .bcd      (w_bcd),
        .overflow (w_cnv_ovf)
    );

    // Digit selection reads the next buffer value so a write coinciding
    // with a scan advance is shown immediately.
    assign w_buf_nxt = w_hex_wr ? w_data_ext :
                       w_done   ? w_bcd      : r_buf;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
        assign w_digit_nz[gi]   = |w_buf_nxt[4*gi +: 4];
        assign w_zero_above[gi] = ~|w_digit_nz[DIGITS-1:gi];
    end

    always_comb begin
        w_nib    = 4'd0;
        w_blank  = 1'b0;
        w_cs_nxt = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = w_buf_nxt[4*i +: 4];
                w_blank     = bus.blank_lz & (i != 0) & w_zero_above[i];
                w_cs_nxt[i] = 1'b0;
            end
        end
    end

    assign w_seg = w_blank ? SEG_BLANK : SEG_CODE[w_nib];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_buf <= '0;
            r_ovf <= 1'b0;
            r_cs  <= '1;
            r_dx  <= SEG_BLANK;
        end else begin
            r_buf <= w_buf_nxt;
            if (w_hex_wr) begin
                r_ovf <= 1'b0;
            end else if (w_done) begin
                r_ovf <= w_cnv_ovf;
            end
            if (r_cnt == c_cnt_last) begin
                r_cnt <= '0;
                r_cs  <= w_cs_nxt;
                r_dx  <= w_seg;
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.ready    = w_ready;
    assign bus.overflow = r_ovf;
    assign bus.cs       = r_cs;
    assign bus.dx       = r_dx;

endmodule
`default_nettype wire

// File: doc/smg_scan_driver.md
# smg_scan_driver

Parametrised multiplexed seven-segment display driver for common-anode modules with active-low digit selects and segment lines. It takes a binary value with a one-cycle load strobe and converts it to decimal with a sequential double-dabble converter, or passes it through as hex nibbles. It then scans `DIGITS` digits at a programmable rate. It is the generalised display back-end for the UART and counter demos, replacing fixed two-digit drivers.

## Interface
- `DIGITS`, 4: number of digit positions; legal range 1–8.
- `DATA_W`, 16: width of `data_in`; must be ≤ 4·`DIGITS`.
- `SCAN_CYC`, 50_000: clock cycles each digit stays lit (1 ms at 50 MHz); must be ≥ 2.
- `clk` in 1: system clock; one clock domain, all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `data_in` in `DATA_W`: unsigned binary value to display.
- `load` in 1: one-cycle strobe; accepted only while `ready`=1.
- `hex_mode` in 1: 1 = hex digits, 0 = decimal; sampled on an accepted `load`.
- `blank_lz` in 1: 1 = blank leading zeros; applied live, not latched.
- `ready` out 1: 1 = idle, can accept `load`.
- `overflow` out 1: last decimal value ≥ 10^`DIGITS`; cleared by any hex load.
- `cs` out `DIGITS`: digit select, one-cold, active-low; `cs[0]` = least significant digit.
- `dx` out 8: segments, active-low; bit 7 = dp (held 1), bits 6:0 = g..a.

## Operation
- Reset values:
  - `cs` = all 1s, `dx` = 8'hFF, `ready` = 1, `overflow` = 0.
  - Display buffer = all zero digits.
  - Scan counter = 0, digit index = 0, converter idle.
- Accepted load (`load`=1, `ready`=1), hex mode: the low 4·`DIGITS` bits of zero-extended `data_in` are written to the buffer as nibbles. `ready` stays 1 and `overflow` is cleared.
- Accepted load, decimal mode: the converter FSM runs.
  - States: IDLE → SHIFT (`DATA_W` iterations) → DONE → IDLE.
  - Each SHIFT iteration: add 3 to every BCD nibble ≥ 5, then shift left one bit, bringing in the next MSB of the captured data.
  - BCD register is 4·`DIGITS` bits, plus carry tracking for `overflow` (any 1 shifted out of the top nibble sets it).
  - DONE writes the buffer and `overflow` atomically and raises `ready`.
- `load` while `ready`=0: ignored, with no effect on the conversion in progress.
- The buffer is only ever written whole; the scan never shows a half-updated value.
- Scan:
  - The counter counts 0..`SCAN_CYC`-1 and wraps.
  - On the wrap, the digit index advances 0..`DIGITS`-1 and then wraps to 0.
  - `cs` drives 0 on bit [index] only. `dx` carries the segment code of buffer digit [index].
- Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E.
- Leading-zero blanking: with `blank_lz`=1, every digit above the most significant nonzero digit outputs `dx`=8'hFF. Digit 0 is never blanked, so value 0 shows C0 on digit 0.
- Reset mid-conversion: the conversion is aborted and all reset values are restored; no partial buffer write.

## Timing
- `cs` and `dx` are registered and change on the cycle after the scan counter reaches `SCAN_CYC`-1.
- The first digit is lit (`cs[0]`=0) `SCAN_CYC` cycles after reset release.
- Hex load accepted at cycle N → buffer updated at N+1; `ready` never drops.
- Decimal load accepted at cycle N:
  - `ready`=0 from N+1 to N+`DATA_W`+1.
  - Buffer and `overflow` are valid, and `ready`=1, at N+`DATA_W`+2.
- A buffer change appears on `dx` at the next digit advance; nothing is refreshed mid-digit.
- Simultaneous scan advance and buffer write: the advancing digit shows the new buffer value.

## Structure
- Package `smg_pkg`:
  - the 16-entry segment-code constant array;
  - `SEG_BLANK` = 8'hFF;
  - converter state enum (IDLE/SHIFT/DONE).
- Sub-module `bin2bcd_seq`: parametrised by `DATA_W`/`DIGITS`, with ports start/busy/done/bcd/overflow.
- Top level holds the scan counter, digit index, buffer, blanking logic and output registers.

## Test plan
All scenarios use `DIGITS`=4, `DATA_W`=16, `SCAN_CYC`=4.
- Reset: hold `rst_n`=0 for 3 cycles → `cs`=4'b1111, `dx`=FF, `ready`=1, `overflow`=0. First active scan after release: `cs`=1110, `dx`=C0.
- Decimal 1234 → `ready` low 17 cycles, `overflow`=0. Scan sequence: `cs` 1110/1101/1011/0111 with `dx` 99/B0/A4/F9, repeating.
- Hex 0xBEEF with `hex_mode`=1 → `ready` stays 1. Digits 0..3 show 8E/86/86/83; a prior `overflow` is cleared.
- Decimal 65535 → `overflow`=1; digits show 5535 (92/B0/92/92).
- Decimal 7 with `blank_lz`=1 → digit 0 `dx`=F8, digits 1–3 `dx`=FF. Decimal 0 → digit 0 C0, others FF. With `blank_lz`=0 → leading C0s shown.
- Busy and reset mid-conversion:
  - `load` of 9999 during a conversion of 42 → ignored; display shows 0042.
  - `rst_n`=0 at SHIFT iteration 8 → `ready`=1, buffer 0000, no late buffer write.
